async_fifo_stream_reader: RTL and testbench

Read-side companion to async_fifo, living entirely in the FIFO's read clock domain. It issues rd_en against the FIFO's empty flag and absorbs the FIFO's 1-cycle registered read latency. The result is presented as a valid/ready stream through a 2-entry output buffer, giving full throughput with no data loss under downstream backpressure. It also provides a synchronous flush and a transferred-word counter for downstream consumers and debug.

---
 rtl/async_fifo_stream_reader_if.sv | 21 ++
 rtl/async_fifo_stream_reader.sv | 92 +++++++++
 tb/tb_async_fifo_stream_reader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_stream_reader_if.sv
// Read-side bundle: async_fifo read port plus the valid/ready output stream.
interface async_fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output fifo_rd_en, m_valid, m_data,
    input  fifo_rd_data, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data,
    output fifo_rd_data, fifo_empty, m_ready
  );
endinterface

// File: rtl/async_fifo_stream_reader.sv
// Pulls words from async_fifo, absorbs its 1-cycle read latency and presents them
// as a valid/ready stream through a 2-entry buffer; adds flush and a handshake counter.
module async_fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   rd_clk,
  input  logic                   rst,
  input  logic                   flush,
  async_fifo_stream_reader_if.master bus,
  output logic [COUNT_WIDTH-1:0] xfer_count,
  output logic                   busy
);

  logic [1:0]             occ_q, occ_d;
  logic                   inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  logic [DATA_WIDTH-1:0]  tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   m_valid_q, m_valid_d;
  logic                   busy_q, busy_d;
  logic                   pop;
  logic [2:0]             level;
  logic                   rd_en;

  // Read issue and next-state; a capture always lands in head when the buffer drains to it.
  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pop        = m_valid_q & bus.m_ready;
    count_d    = count_q + COUNT_WIDTH'(pop);
    level      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    rd_en      = !rst && !flush && !bus.fifo_empty && (level < 3'd2);
    inflight_d = rd_en;

    if (flush) begin
      occ_d = 2'd0;
    end else begin
      unique case ({inflight_q, pop})
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_d = tail_q;
            tail_d = bus.fifo_rd_data;
          end else begin
            head_d = bus.fifo_rd_data;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) head_d = bus.fifo_rd_data;
          else               tail_d = bus.fifo_rd_data;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        default: ;
      endcase
    end

    m_valid_d = (occ_d != 2'd0);
    busy_d    = (occ_d != 2'd0) || inflight_d;
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      m_valid_q  <= m_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = head_q;
  assign xfer_count     = count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_async_fifo_stream_reader.sv
// Bench: behavioural FIFO, word-age scoreboard of outstanding reads, random and directed traffic.
module tb_async_fifo_stream_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    logic [DW-1:0] d;
    int            age;
  } ent_t;

  logic          rd_clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] xfer_count;
  logic          busy;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  async_fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  async_fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .rd_clk     (rd_clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .xfer_count (xfer_count),
    .busy       (busy)
  );

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0] mem[$];
  ent_t          sb[$];
  int            exp_cnt = 0;
  bit            model_ok = 1'b0;
  int            n_cmp = 0;
  int            n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural async_fifo read side: registered rd_data, empty reflects contents after the edge.
  always @(posedge rd_clk) begin
    if (bus.fifo_rd_en && mem.size() > 0) bus.fifo_rd_data <= mem.pop_front();
    if (wr_en) mem.push_back(wr_data);
    bus.fifo_empty <= (mem.size() == 0);
  end

  // Reference: each word read from the FIFO is outstanding until popped or discarded;
  // it is visible on the stream from its second edge after the read onward.
  always @(negedge rd_clk) begin
    bit vexp, pop, rexp;
    int lvl;
    vexp = (sb.size() > 0) && (sb[0].age >= 2);
    pop  = vexp && (bus.m_ready === 1'b1);
    lvl  = sb.size() - int'(pop);
    rexp = !rst && !flush && (bus.fifo_empty === 1'b0) && (lvl < 2);
    if (model_ok) begin
      chk("m_valid", 32'(bus.m_valid), 32'(vexp));
      if (vexp) chk("m_data", 32'(bus.m_data), 32'(sb[0].d));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      chk("xfer_count", 32'(xfer_count), 32'(exp_cnt % (1 << CW)));
      chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(rexp));
    end
    if (pop) begin
      void'(sb.pop_front());
      exp_cnt++;
    end
    if (rst) begin
      sb.delete();
      exp_cnt  = 0;
      model_ok = 1'b1;
    end else if (flush) begin
      sb.delete();
    end else if (rexp && mem.size() > 0) begin
      sb.push_back('{d: mem[0], age: 0});
    end
    foreach (sb[i]) sb[i].age++;
    if (model_ok) chk("occ_plus_inflight_le_2", 32'(sb.size() <= 2), 32'd1);
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(base + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    bus.m_ready = 1'b1;
    while ((mem.size() != 0 || bus.fifo_empty !== 1'b1 || busy !== 1'b0) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_within_budget", 32'(k < budget), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, k, written;
    bus.m_ready = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    @(negedge rd_clk);
    chk("reset_m_data", 32'(bus.m_data), 32'd0);
    chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset_xfer_count", 32'(xfer_count), 32'd0);
    tick();

    // Burst 0x64..0x6B with m_ready high
    bus.m_ready = 1'b1;
    push_words(8'h64, 8);
    drain(100);
    chk("burst_xfer_count", 32'(xfer_count), 32'd8);
    chk("burst_busy_end", 32'(busy), 32'd0);

    // Single-word latency
    push_words(8'hA5, 1);
    drain(50);

    // Backpressure: only two reads may be issued while m_ready is low
    bus.m_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      wr_en   = (i < 8);
      wr_data = DW'(8'h10 + i);
      @(negedge rd_clk);
      pulses += int'(bus.fifo_rd_en);
      tick();
    end
    wr_en = 1'b0;
    chk("bp_rd_en_pulses", 32'(pulses), 32'd2);
    chk("bp_head_word", 32'(bus.m_data), 32'h10);
    drain(100);

    // Randomized writes, ready and rare flushes
    written = 0;
    k = 0;
    while (written < 200 && k < 4000) begin
      wr_en       = ($urandom_range(0, 99) < 60);
      wr_data     = DW'($urandom);
      bus.m_ready = $urandom_range(0, 1) == 1;
      flush       = ($urandom_range(0, 63) == 0);
      if (wr_en) written++;
      tick();
      k++;
    end
    wr_en = 1'b0;
    flush = 1'b0;
    drain(200);

    // Flush with one word buffered and one in flight
    bus.m_ready = 1'b0;
    push_words(8'h30, 3);
    k = 0;
    while (!(sb.size() == 2 && sb[0].age >= 2 && sb[1].age == 1) && k < 20) begin
      tick();
      k++;
    end
    chk("flush_setup_within_budget", 32'(k < 20), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge rd_clk);
    chk("m_valid_after_flush", 32'(bus.m_valid), 32'd0);
    tick();
    bus.m_ready = 1'b1;
    @(negedge rd_clk);
    k = 0;
    while (bus.m_valid !== 1'b1 && k < 20) begin
      @(negedge rd_clk);
      k++;
    end
    chk("first_word_after_flush", 32'(bus.m_data), 32'h32);
    tick();
    drain(50);

    // Reset mid-stream with words buffered
    bus.m_ready = 1'b0;
    push_words(8'h50, 4);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge rd_clk);
    chk("rd_en_during_rst", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge rd_clk);
    chk("post_rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("post_rst_xfer_count", 32'(xfer_count), 32'd0);
    tick();
    drain(50);

    // Counter wrap: restart from zero, then 17 handshakes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    push_words(8'h70, 17);
    drain(100);
    chk("wrap_xfer_count", 32'(xfer_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
